uart_rx_cfg: RTL and testbench

Parametrised UART receiver that replaces the fixed 8N1 receiver wherever a serial input enters the 100 MHz fabric. It supports configurable data width, parity and stop bits, and has an input synchroniser. Each received character is held in an output register with a valid/ready handshake. Framing, parity and overrun errors are reported alongside the data.

---
 rtl/uart_rx_cfg.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver for the fabric clock domain.
//
// Receives DATA_BITS data bits (LSB first), an optional parity bit (PARITY:
// 0 none, 1 odd, 2 even) and STOP_BITS stop bits. The asynchronous line goes
// through a 2-flop synchroniser first. Each completed character is held in an
// output register until the consumer accepts it.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - every sample is the 2-of-3 majority of the last three
//               synchronised line values (current and two previous cycles)
//   undefined - every sample is the synchronised line value itself
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   data       out  last received character (bit 0 = first data bit)
//   valid      out  data and flags held, high until accepted
//   ready      in   consumer accept
//   parity_err out  parity mismatch of the held character (0 when PARITY = 0)
//   frame_err  out  a stop bit of the held character was sampled low
//   overrun    out  one-cycle pulse: a character completed while valid && !ready
//   dbg_state  out  current receiver state encoding
//
// Handshake: a character is transferred on every rising edge where
// valid && ready. valid then falls on that edge unless a new character
// completes on the same edge, in which case valid stays high with new data.

module uart_rx_cfg #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic [2:0]           dbg_state
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_e;

   state_e               state_q;
   logic                 s1_q, s2_q;
   logic                 samp;
   logic [CW-1:0]        cnt_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr_q, ferr_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, perr_out_q, ferr_out_q, overrun_q;
   logic                 start_tick, bit_tick;

   // Synchroniser; idle level is high so reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= rx;
         s2_q <= s1_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] = s2 one cycle ago, hist_q[1] = s2 two cycles ago.
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], s2_q};
   end

   assign samp = (s2_q & hist_q[0]) | (s2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
   assign samp = s2_q;
`endif

   assign start_tick = (cnt_q == CW'(HALF - 1));
   assign bit_tick   = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (valid_q && ready) valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!s2_q) state_q <= S_START;
            end
            S_START: begin
               if (start_tick) begin
                  cnt_q  <= '0;
                  bit_q  <= '0;
                  perr_q <= 1'b0;
                  ferr_q <= 1'b0;
                  // A high sample mid start bit is a glitch: drop it silently.
                  state_q <= samp ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  cnt_q   <= '0;
                  shift_q <= {samp, shift_q[DATA_BITS-1:1]};
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     bit_q   <= '0;
                     state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  cnt_q   <= '0;
                  // XOR of data and parity bit is 1 for odd total; odd parity inverts.
                  perr_q  <= (^shift_q) ^ samp ^ (PARITY == 1);
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  cnt_q  <= '0;
                  ferr_q <= ferr_q | ~samp;
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                     bit_q      <= '0;
                     data_q     <= shift_q;
                     perr_out_q <= perr_q;
                     ferr_out_q <= ferr_q | ~samp;
                     // Completion wins over a same-edge accept.
                     valid_q    <= 1'b1;
                     overrun_q  <= valid_q & ~ready;
                     // Leave mid stop bit so the next start edge resynchronises.
                     state_q    <= samp ? S_IDLE : S_BREAK;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               if (s2_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_out_q;
   assign overrun    = overrun_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers with different frame formats
// (8N1, 8E1, 9N2, 7O1), each on its own line, driven by frame tasks and
// compared against a frame-level model of the expected character and flags.

module tb_uart_rx_cfg;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = 10;
   localparam int HALF     = 5;
   localparam int NI       = 4;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BREAK = 3'd5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_v   [NI];
   logic       rdy_v  [NI];
   logic       vld_v  [NI];
   logic       perr_v [NI];
   logic       ferr_v [NI];
   logic       ovr_v  [NI];
   logic [8:0] dat_v  [NI];
   logic [2:0] st_v   [NI];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [10:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DB = (g == 2) ? 9 : (g == 3) ? 7 : 8;
      localparam int PM = (g == 1) ? 2 : (g == 3) ? 1 : 0;
      localparam int SB = (g == 2) ? 2 : 1;
      logic [DB-1:0] d;
      uart_rx_cfg #(
         .CLK_FREQ (CLK_FREQ),
         .BAUD_RATE(BAUD),
         .DATA_BITS(DB),
         .PARITY   (PM),
         .STOP_BITS(SB)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .rx        (rx_v[g]),
         .data      (d),
         .valid     (vld_v[g]),
         .ready     (rdy_v[g]),
         .parity_err(perr_v[g]),
         .frame_err (ferr_v[g]),
         .overrun   (ovr_v[g]),
         .dbg_state (st_v[g])
      );
      assign dat_v[g] = 9'(d);
   end

   function automatic int cfg_db(int i);
      return (i == 2) ? 9 : (i == 3) ? 7 : 8;
   endfunction
   function automatic int cfg_par(int i);
      return (i == 1) ? 2 : (i == 3) ? 1 : 0;
   endfunction
   function automatic int cfg_sb(int i);
      return (i == 2) ? 2 : 1;
   endfunction

   // Cycles from driving the start bit low to valid being visible:
   // 2 synchroniser cycles, half a bit, one bit per frame element, +1.
   function automatic int lat(int i);
      return 3 + HALF + (cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i)) * CPB;
   endfunction

   // Reference: {parity_err, frame_err, data} for a frame as transmitted.
   function automatic logic [10:0] model(int i, int unsigned val, bit pbit, int stop_mask);
      int          db   = cfg_db(i);
      int          pm   = cfg_par(i);
      int          sb   = cfg_sb(i);
      int unsigned d    = val % (32'd1 << db);
      int          ones = $countones(d) + int'(pbit);
      bit          pe;
      bit          fe;
      pe = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : 1'b0;
      fe = (stop_mask % (1 << sb)) != 0;
      return {pe, fe, 9'(d)};
   endfunction

   // ---------------- monitor ----------------
   int         ovr_cnt  [NI];
   int         ovr_cyc  [NI];
   logic [8:0] ovr_dat  [NI];
   int         rise_cnt [NI];
   int         rise_cyc [NI];
   bit         vld_prev [NI];

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (ovr_v[i] === 1'b1) begin
            ovr_cnt[i]++;
            ovr_cyc[i] = cyc;
            ovr_dat[i] = dat_v[i];
         end
         if (vld_v[i] === 1'b1 && !vld_prev[i]) begin
            rise_cnt[i]++;
            rise_cyc[i] = cyc;
         end
         vld_prev[i] = (vld_v[i] === 1'b1);
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int i, input logic lvl, input int n);
      rx_v[i] = lvl;
      tick(n);
   endtask

   int last_start[NI];

   task automatic send_frame(input int i, input int unsigned val, input bit pbit,
                             input int stop_mask, input int gap, input bit glitch0);
      int db = cfg_db(i);
      int pm = cfg_par(i);
      int sb = cfg_sb(i);
      last_start[i] = cyc;
      drive(i, 1'b0, CPB);
      for (int b = 0; b < db; b++) begin
         logic lv;
         lv = val[b];
         if (glitch0 && b == 0) begin
            drive(i, lv, HALF);
            drive(i, ~lv, 1);
            drive(i, lv, CPB - HALF - 1);
         end else begin
            drive(i, lv, CPB);
         end
      end
      if (pm != 0) drive(i, pbit, CPB);
      for (int s = 0; s < sb; s++) drive(i, ~stop_mask[s], CPB);
      drive(i, 1'b1, gap);
   endtask

   task automatic check_frame(input string tag, input int i);
      logic [10:0] e;
      int w;
      w = 0;
      while (vld_v[i] !== 1'b1 && w < 200) begin
         tick(1);
         w++;
      end
      check({tag, "_valid"}, 32'(vld_v[i]), 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_expq"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_data"}, 32'(dat_v[i]), 32'(e[8:0]));
         check({tag, "_perr"}, 32'(perr_v[i]), 32'(e[10]));
         check({tag, "_ferr"}, 32'(ferr_v[i]), 32'(e[9]));
      end
   endtask

   task automatic accept(input string tag, input int i);
      rdy_v[i] = 1'b1;
      tick(1);
      rdy_v[i] = 1'b0;
      check({tag, "_accept"}, 32'(vld_v[i]), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   int          base_rise;
   int          base_ovr;
   int          ovr_base_all[NI];
   int          ri;
   int unsigned rv;
   bit          rp;
   int          rs;
   int          rg;
   logic [8:0]  glitch_exp;

   initial begin
      for (int i = 0; i < NI; i++) begin
         rx_v[i]  = 1'b1;
         rdy_v[i] = 1'b0;
      end
      rst = 1'b1;
      tick(5);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst%0d_valid", i), 32'(vld_v[i]), 32'd0);
         check($sformatf("rst%0d_data", i), 32'(dat_v[i]), 32'd0);
         check($sformatf("rst%0d_perr", i), 32'(perr_v[i]), 32'd0);
         check($sformatf("rst%0d_ferr", i), 32'(ferr_v[i]), 32'd0);
         check($sformatf("rst%0d_ovr", i), 32'(ovr_v[i]), 32'd0);
         check($sformatf("rst%0d_state", i), 32'(st_v[i]), 32'(ST_IDLE));
      end
      rst = 1'b0;
      tick(20);

      // 8N1 0xA5 with ready low: valid rises once, holds, exact latency.
      base_rise = rise_cnt[0];
      base_ovr  = ovr_cnt[0];
      exp_q.push_back(model(0, 32'hA5, 1'b0, 0));
      send_frame(0, 32'hA5, 1'b0, 0, 20, 1'b0);
      check_frame("a5", 0);
      check("a5_latency", 32'(rise_cyc[0] - last_start[0]), 32'(lat(0)));
      tick(30);
      check("a5_hold", 32'(vld_v[0]), 32'd1);
      check("a5_rises", 32'(rise_cnt[0] - base_rise), 32'd1);
      check("a5_no_ovr", 32'(ovr_cnt[0] - base_ovr), 32'd0);
      accept("a5", 0);

      // Even parity, 0x37: wrong parity bit then correct one.
      exp_q.push_back(model(1, 32'h37, 1'b0, 0));
      send_frame(1, 32'h37, 1'b0, 0, 20, 1'b0);
      check_frame("par_bad", 1);
      check("par_latency", 32'(rise_cyc[1] - last_start[1]), 32'(lat(1)));
      accept("par_bad", 1);
      exp_q.push_back(model(1, 32'h37, 1'b1, 0));
      send_frame(1, 32'h37, 1'b1, 0, 20, 1'b0);
      check_frame("par_ok", 1);
      accept("par_ok", 1);

      // Break: line low for 20 bit times.
      base_rise = rise_cnt[0];
      drive(0, 1'b0, 150);
      check("brk_valid", 32'(vld_v[0]), 32'd1);
      check("brk_data", 32'(dat_v[0]), 32'd0);
      check("brk_ferr", 32'(ferr_v[0]), 32'd1);
      check("brk_perr", 32'(perr_v[0]), 32'd0);
      accept("brk", 0);
      drive(0, 1'b0, 50);
      check("brk_state", 32'(st_v[0]), 32'(ST_BREAK));
      check("brk_no_valid", 32'(vld_v[0]), 32'd0);
      check("brk_rises", 32'(rise_cnt[0] - base_rise), 32'd1);
      drive(0, 1'b1, 20);
      check("brk_exit", 32'(st_v[0]), 32'(ST_IDLE));
      exp_q.push_back(model(0, 32'h5A, 1'b0, 0));
      send_frame(0, 32'h5A, 1'b0, 0, 20, 1'b0);
      check_frame("after_brk", 0);
      accept("after_brk", 0);

      // False start: 3-cycle low pulse.
      base_rise = rise_cnt[0];
      drive(0, 1'b0, 3);
      drive(0, 1'b1, 30);
      check("fs_valid", 32'(vld_v[0]), 32'd0);
      check("fs_state", 32'(st_v[0]), 32'(ST_IDLE));
      check("fs_rises", 32'(rise_cnt[0] - base_rise), 32'd0);

      // Reset mid data bit with a character still held.
      exp_q.push_back(model(0, 32'h81, 1'b0, 0));
      send_frame(0, 32'h81, 1'b0, 0, 20, 1'b0);
      check_frame("pre_rst", 0);
      drive(0, 1'b0, CPB);
      drive(0, 1'b1, 15);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("mrst_valid", 32'(vld_v[0]), 32'd0);
      check("mrst_data", 32'(dat_v[0]), 32'd0);
      check("mrst_perr", 32'(perr_v[0]), 32'd0);
      check("mrst_ferr", 32'(ferr_v[0]), 32'd0);
      check("mrst_ovr", 32'(ovr_v[0]), 32'd0);
      check("mrst_state", 32'(st_v[0]), 32'(ST_IDLE));
      drive(0, 1'b1, 20);
      exp_q.push_back(model(0, 32'h3C, 1'b0, 0));
      send_frame(0, 32'h3C, 1'b0, 0, 20, 1'b0);
      check_frame("post_rst", 0);
      accept("post_rst", 0);

      // Back-to-back 0x11, 0x22 with ready low: one overrun pulse.
      base_ovr = ovr_cnt[0];
      send_frame(0, 32'h11, 1'b0, 0, 0, 1'b0);
      exp_q.push_back(model(0, 32'h22, 1'b0, 0));
      send_frame(0, 32'h22, 1'b0, 0, 20, 1'b0);
      check("b2b_ovr_count", 32'(ovr_cnt[0] - base_ovr), 32'd1);
      check("b2b_ovr_data", 32'(ovr_dat[0]), 32'h22);
      check("b2b_ovr_time", 32'(ovr_cyc[0] - last_start[0]), 32'(lat(0)));
      check_frame("b2b", 0);
      accept("b2b", 0);

      // 9 data bits, 2 stop bits.
      exp_q.push_back(model(2, 32'h1FF, 1'b0, 0));
      send_frame(2, 32'h1FF, 1'b0, 0, 20, 1'b0);
      check_frame("w9", 2);
      check("w9_latency", 32'(rise_cyc[2] - last_start[2]), 32'(lat(2)));
      accept("w9", 2);

      // One-cycle high glitch on the data bit 0 sample point.
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 9'h054;
`else
      glitch_exp = 9'h055;
`endif
      send_frame(0, 32'h54, 1'b0, 0, 20, 1'b1);
      check("glitch_valid", 32'(vld_v[0]), 32'd1);
      check("glitch_data", 32'(dat_v[0]), 32'(glitch_exp));
      accept("glitch", 0);

      // Randomised frames across all formats.
      for (int i = 0; i < NI; i++) ovr_base_all[i] = ovr_cnt[i];
      for (int n = 0; n < 40; n++) begin
         ri = $urandom_range(0, NI - 1);
         rv = $urandom;
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         rg = $urandom_range(CPB, 3 * CPB);
         exp_q.push_back(model(ri, rv, rp, rs));
         send_frame(ri, rv, rp, rs, rg, 1'b0);
         check_frame($sformatf("rnd%0d_i%0d", n, ri), ri);
         tick($urandom_range(0, 5));
         accept($sformatf("rnd%0d", n), ri);
      end
      for (int i = 0; i < NI; i++)
         check($sformatf("rnd_no_ovr%0d", i), 32'(ovr_cnt[i] - ovr_base_all[i]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
